// File: rtl/jpeg_color_pkg.sv
// Shared colour-conversion constants for the JPEG encode/decode colour stages.
// Fixed-point coefficients are scaled by 2^COEF_FRAC.
package jpeg_color_pkg;

   typedef logic [23:0] pixel24_t;

   localparam int COEF_FRAC     = 13;
   localparam int ROUND_HALF    = 4096;
   localparam int CHROMA_OFFSET = 128;

   // Inverse (YCbCr -> RGB) coefficients.
   localparam int KR_CR = 11485;
   localparam int KG_CB = 2819;
   localparam int KG_CR = 5850;
   localparam int KB_CB = 14516;

   // Forward (RGB -> YCbCr) coefficients used by the encoder-side stage.
   localparam int KY_R  = 2449;
   localparam int KY_G  = 4809;
   localparam int KY_B  = 934;
   localparam int KCB_R = 1382;
   localparam int KCB_G = 2714;
   localparam int KCB_B = 4096;
   localparam int KCR_R = 4096;
   localparam int KCR_G = 3430;
   localparam int KCR_B = 666;

endpackage

// File: rtl/rgb_round_clamp.sv
// Rounds a 23-bit signed fixed-point channel sum to an 8-bit pixel, saturating to 0..255.
// The clamp flag output exists only with YCBCR2RGB_SATCNT_EN.
module rgb_round_clamp
   import jpeg_color_pkg::*;
(
   input  logic signed [22:0] sum_i,
   output logic [7:0]         pix_o
`ifdef YCBCR2RGB_SATCNT_EN
   ,
   output logic               clamp_o
`endif
);

   localparam logic signed [22:0] RND = 23'(ROUND_HALF);

   logic signed [22:0] rounded;
   logic signed [9:0]  whole;

   assign rounded = sum_i + RND;
   assign whole   = 10'(rounded >>> COEF_FRAC);

   always_comb begin
      pix_o = whole[7:0];
      if (whole[9]) begin
         pix_o = 8'd0;
      end else if (whole[8]) begin
         pix_o = 8'd255;
      end
   end

`ifdef YCBCR2RGB_SATCNT_EN
   // Low clamp is judged on the pre-rounding sum, so sums just below zero also count.
   assign clamp_o = sum_i[22] | (~whole[9] & whole[8]);
`endif

endmodule

// File: rtl/ycbcr2rgb.sv
// Three-stage pipelined JFIF full-range YCbCr -> RGB converter with full backpressure.
// Optional clamp-event counter (sat_count) enabled by YCBCR2RGB_SATCNT_EN.
module ycbcr2rgb
   import jpeg_color_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     in_valid,
   output logic     in_ready,
   input  pixel24_t data_in,
   output logic     out_valid,
   input  logic     out_ready,
   output pixel24_t data_out
`ifdef YCBCR2RGB_SATCNT_EN
   ,
   output logic [15:0] sat_count
`endif
);

   localparam logic signed [22:0] C_KR_CR = 23'(KR_CR);
   localparam logic signed [22:0] C_KG_CB = 23'(KG_CB);
   localparam logic signed [22:0] C_KG_CR = 23'(KG_CR);
   localparam logic signed [22:0] C_KB_CB = 23'(KB_CB);
   localparam logic signed [8:0]  C_OFS   = 9'(CHROMA_OFFSET);

   // Handshake: a beat moves on in_valid&in_ready / out_valid&out_ready; the whole
   // pipe advances together whenever the output slot is empty or being taken.
   logic adv;
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   logic v1_q, v2_q, v3_q;

   logic [7:0]         y1_q;
   logic signed [8:0]  cb1_q, cr1_q;
   logic signed [8:0]  cb1_d, cr1_d;

   logic signed [22:0] ys2_q, pr2_q, pgb2_q, pgr2_q, pb2_q;
   logic signed [22:0] ys2_d, pr2_d, pgb2_d, pgr2_d, pb2_d;

   logic signed [22:0] r_sum, g_sum, b_sum;
   logic [7:0]         r_pix, g_pix, b_pix;
   pixel24_t           data_q;

   assign cb1_d = $signed({1'b0, data_in[15:8]})  - C_OFS;
   assign cr1_d = $signed({1'b0, data_in[23:16]}) - C_OFS;

   assign ys2_d  = $signed({2'b00, y1_q, 13'd0});
   assign pr2_d  = C_KR_CR * 23'(cr1_q);
   assign pgb2_d = C_KG_CB * 23'(cb1_q);
   assign pgr2_d = C_KG_CR * 23'(cr1_q);
   assign pb2_d  = C_KB_CB * 23'(cb1_q);

   assign r_sum = ys2_q + pr2_q;
   assign g_sum = ys2_q - pgb2_q - pgr2_q;
   assign b_sum = ys2_q + pb2_q;

`ifdef YCBCR2RGB_SATCNT_EN
   logic r_clamp, g_clamp, b_clamp;

   rgb_round_clamp u_r (.sum_i(r_sum), .pix_o(r_pix), .clamp_o(r_clamp));
   rgb_round_clamp u_g (.sum_i(g_sum), .pix_o(g_pix), .clamp_o(g_clamp));
   rgb_round_clamp u_b (.sum_i(b_sum), .pix_o(b_pix), .clamp_o(b_clamp));
`else
   rgb_round_clamp u_r (.sum_i(r_sum), .pix_o(r_pix));
   rgb_round_clamp u_g (.sum_i(g_sum), .pix_o(g_pix));
   rgb_round_clamp u_b (.sum_i(b_sum), .pix_o(b_pix));
`endif

   // Valid bits and output register; data_out only loads from a valid slot so it
   // reads zero until the first real pixel after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         data_q <= '0;
      end else if (adv) begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (v2_q) begin
            data_q <= {b_pix, g_pix, r_pix};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         y1_q   <= data_in[7:0];
         cb1_q  <= cb1_d;
         cr1_q  <= cr1_d;
         ys2_q  <= ys2_d;
         pr2_q  <= pr2_d;
         pgb2_q <= pgb2_d;
         pgr2_q <= pgr2_d;
         pb2_q  <= pb2_d;
      end
   end

   assign out_valid = v3_q;
   assign data_out  = data_q;

`ifdef YCBCR2RGB_SATCNT_EN
   logic        clamp3_q;
   logic [15:0] sat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         clamp3_q <= 1'b0;
         sat_q    <= 16'd0;
      end else begin
         if (adv && v2_q) begin
            clamp3_q <= r_clamp | g_clamp | b_clamp;
         end
         if (v3_q && out_ready && clamp3_q && (sat_q != 16'hFFFF)) begin
            sat_q <= sat_q + 16'd1;
         end
      end
   end

   assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: directed test-plan vectors, backpressure,
// mid-stream reset, random pixels and an RGB->YCbCr->RGB loopback.
module tb_ycbcr2rgb;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] data_out;
`ifdef YCBCR2RGB_SATCNT_EN
   logic [15:0] sat_count;
`endif

   ycbcr2rgb dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
`ifdef YCBCR2RGB_SATCNT_EN
      ,
      .sat_count (sat_count)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   // entry: [49] loopback check, [48:25] original RGB, [24] clamp, [23:0] expected RGB
   logic [49:0] exp_q[$];
   int          lat_q[$];
   int          errors = 0;
   int          checks = 0;
   int          exp_sat = 0;
   bit          chk_lat = 1'b0;
   bit          held_valid = 1'b0;
   logic [23:0] held_data;
   int          rdy_mode = 0;
   int          rdy_phase = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [24:0] ref_px(input logic [23:0] p);
      int y, cb, cr, v;
      int s[3];
      logic [24:0] res;
      res = '0;
      y  = p[7:0];
      cb = p[15:8];
      cr = p[23:16];
      cb = cb - 128;
      cr = cr - 128;
      s[0] = y * 8192 + 11485 * cr;
      s[1] = y * 8192 - 2819 * cb - 5850 * cr;
      s[2] = y * 8192 + 14516 * cb;
      for (int c = 0; c < 3; c++) begin
         v = (s[c] + 4096) >>> 13;
         if (s[c] < 0 || v > 255) res[24] = 1'b1;
         if (v < 0) v = 0;
         if (v > 255) v = 255;
         res[8*c +: 8] = 8'(v);
      end
      return res;
   endfunction

   function automatic int clip8(input real x);
      int v;
      v = int'(x);
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      return v;
   endfunction

   // Encoder-side colour stage: JFIF RGB -> YCbCr, returns {Cr, Cb, Y}.
   function automatic logic [23:0] fwd_px(input logic [23:0] rgb);
      real r, g, b;
      int y, cb, cr;
      r = rgb[7:0];
      g = rgb[15:8];
      b = rgb[23:16];
      y  = clip8(0.299 * r + 0.587 * g + 0.114 * b);
      cb = clip8(-0.168736 * r - 0.331264 * g + 0.5 * b + 128.0);
      cr = clip8(0.5 * r - 0.418688 * g - 0.081312 * b + 128.0);
      return {8'(cr), 8'(cb), 8'(y)};
   endfunction

   // ---------------- drivers ----------------
   task automatic send(input logic [23:0] p, input logic [24:0] e, input bit lb, input logic [23:0] orig);
      int n;
      in_valid = 1'b1;
      data_in  = p;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stuck at 0 for pixel %0h", p);
      end else begin
         exp_q.push_back({lb, orig, e});
         lat_q.push_back(cyc + 3);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      data_in  = 24'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic flush_model();
      exp_q.delete();
      lat_q.delete();
      exp_sat    = 0;
      held_valid = 1'b0;
   endtask

   // out_ready patterns: 0 always ready, 1 repeating 1,0,0, 2 random, other held low
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (rdy_phase == 0);
               rdy_phase = (rdy_phase + 1) % 3;
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic [49:0] e;
      int          due;
      int          d;
      forever begin
         @(negedge clk);
         if (!rst) begin
`ifdef YCBCR2RGB_SATCNT_EN
            check("sat_count", 32'(sat_count), 32'(exp_sat));
`endif
            if (held_valid) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_data", 32'(data_out), 32'(held_data));
               held_valid = 1'b0;
            end
            if (out_valid) begin
               check("in_ready_eq_out_ready", 32'(in_ready), 32'(out_ready));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %0h expected none", data_out);
               end else begin
                  e   = exp_q.pop_front();
                  due = lat_q.pop_front();
                  check("data_out", 32'(data_out), 32'(e[23:0]));
                  if (chk_lat) check("latency_cycle", 32'(cyc), 32'(due));
                  if (e[24] && exp_sat < 65535) exp_sat++;
                  if (e[49]) begin
                     for (int c = 0; c < 3; c++) begin
                        d = int'(data_out[8*c +: 8]) - int'(e[25 + 8*c +: 8]);
                        checks++;
                        if (d > 2 || d < -2) begin
                           errors++;
                           $display("FAIL loopback ch%0d: got %0d original %0d", c,
                                    data_out[8*c +: 8], e[25 + 8*c +: 8]);
                        end
                     end
                  end
               end
            end else if (out_valid) begin
               held_valid = 1'b1;
               held_data  = data_out;
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   logic [23:0] px;
   logic [23:0] rgb;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      data_in  = 24'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_data_out", 32'(data_out), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef YCBCR2RGB_SATCNT_EN
      check("reset_sat_count", 32'(sat_count), 32'd0);
`endif
      @(posedge clk);
      #1;
      idle(4);
      @(negedge clk);
      check("idle_data_out_zero", 32'(data_out), 32'd0);
      @(posedge clk);
      #1;

      // Directed vectors with exact 3-cycle latency
      chk_lat  = 1'b1;
      rdy_mode = 0;
      send(24'h808080, {1'b0, 24'h808080}, 1'b0, 24'h0);
      send(24'h808000, {1'b0, 24'h000000}, 1'b0, 24'h0);
      send(24'h8080FF, {1'b0, 24'hFFFFFF}, 1'b0, 24'h0);
      idle(2);
      send(24'hFF554C, {1'b1, 24'h0000FE}, 1'b0, 24'h0);
      send(24'hFFFFFF, {1'b1, 24'hFF79FF}, 1'b0, 24'h0);
      drain();
      chk_lat = 1'b0;
`ifdef YCBCR2RGB_SATCNT_EN
      @(negedge clk);
      check("sat_after_directed", 32'(sat_count), 32'd2);
      @(posedge clk);
      #1;
`endif

      // Backpressure: 8 distinct back-to-back pixels under 1,0,0 out_ready
      rdy_mode  = 1;
      rdy_phase = 0;
      for (int i = 0; i < 8; i++) begin
         px = {8'(16 * i + 7), 8'(255 - 20 * i), 8'(30 * i + 3)};
         send(px, ref_px(px), 1'b0, 24'h0);
      end
      drain();

      // Mid-stream reset with three pixels in flight
      rdy_mode = 3;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         px = 24'($urandom);
         send(px, ref_px(px), 1'b0, 24'h0);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      flush_model();
      @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_data_out", 32'(data_out), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      rdy_mode = 0;
      @(posedge clk);
      #1;
      idle(8);
      check("midrst_no_leak", 32'(exp_q.size()), 32'd0);

      // Random pixels under random backpressure and bubbles
      rdy_mode = 2;
      for (int i = 0; i < 200; i++) begin
         px = 24'($urandom);
         send(px, ref_px(px), 1'b0, 24'h0);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      drain();

      // Loopback through the encoder colour stage
      for (int i = 0; i < 256; i++) begin
         rgb = 24'($urandom);
         px  = fwd_px(rgb);
         send(px, ref_px(px), 1'b1, rgb);
      end
      drain();
      rdy_mode = 0;
      idle(4);

`ifdef YCBCR2RGB_SATCNT_EN
      @(negedge clk);
      check("sat_final", 32'(sat_count), 32'(exp_sat));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
